// File: rtl/banked_scalar_reg_file_pkg.sv
// Shared datapath types for the scalar register file: data word, write-source
// select and the re-initialisation sweep state.
package banked_scalar_reg_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        ALU_OUT   = 2'd0,
        LSU_OUT   = 2'd1,
        IMMEDIATE = 2'd2
    } reg_input_mux_t;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } regfile_init_state_t;

endpackage

// File: rtl/banked_scalar_reg_file.sv
// Multi-warp scalar register file: one bank per warp, a valid/ready read port
// with registered response and write bypass, and a per-warp clearing sweep.
module banked_scalar_reg_file
    import banked_scalar_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_WARPS  = 4,
    parameter int NUM_REGS   = 32,
    parameter int MASK_REG   = 1,
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RW = $clog2(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 rd_req_valid,
    output logic                                 rd_req_ready,
    input  logic [WW-1:0]                        rd_warp,
    input  logic [RW-1:0]                        rs1_addr,
    input  logic [RW-1:0]                        rs2_addr,
    output logic                                 rd_resp_valid,
    output logic [DATA_WIDTH-1:0]                rs1_data,
    output logic [DATA_WIDTH-1:0]                rs2_data,
    input  logic                                 wr_en,
    input  logic [WW-1:0]                        wr_warp,
    input  logic [RW-1:0]                        wr_addr,
    input  reg_input_mux_t                       wr_mux,
    input  logic [DATA_WIDTH-1:0]                alu_out,
    input  logic [DATA_WIDTH-1:0]                lsu_out,
    input  logic [DATA_WIDTH-1:0]                wr_immediate,
    input  logic                                 init_valid,
    input  logic [WW-1:0]                        init_warp,
    output logic                                 init_busy,
    output logic [NUM_WARPS-1:0][DATA_WIDTH-1:0] exec_mask
);

    regfile_init_state_t   state;
    logic [WW-1:0]         sweep_warp;
    logic [RW-1:0]         sweep_idx;
    logic [DATA_WIDTH-1:0] regs [NUM_WARPS][NUM_REGS];

    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rs1_next;
    logic [DATA_WIDTH-1:0] rs2_next;
    logic                  wr_accept;
    logic                  rd_fire;

    assign init_busy    = (state == RF_CLEAR);
    assign rd_req_ready = !(init_busy && (rd_warp == sweep_warp));
    assign rd_fire      = rd_req_valid && rd_req_ready;

    // NOTE: every signal gets a value before the case/ifs, so no latch is inferred.
    always_comb begin
        wr_data   = '0;
        wr_accept = wr_en && (wr_addr != '0) && !(init_busy && (wr_warp == sweep_warp));
        case (wr_mux)
            ALU_OUT:   wr_data = alu_out;
            LSU_OUT:   wr_data = lsu_out;
            IMMEDIATE: wr_data = wr_immediate;
            default: begin
                wr_accept = 1'b0;
                if (wr_en) $error("banked_scalar_reg_file: unknown wr_mux %0d, write dropped", wr_mux);
            end
        endcase

        // Same-cycle write forwards into the read response; register 0 always reads zero.
        rs1_next = regs[rd_warp][rs1_addr];
        if (wr_accept && (wr_warp == rd_warp) && (wr_addr == rs1_addr)) rs1_next = wr_data;
        if (rs1_addr == '0) rs1_next = '0;

        rs2_next = regs[rd_warp][rs2_addr];
        if (wr_accept && (wr_warp == rd_warp) && (wr_addr == rs2_addr)) rs2_next = wr_data;
        if (rs2_addr == '0) rs2_next = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the banks are flip-flops with architecturally defined reset contents, so they are reset like any other state.
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs[w][r] <= (r == MASK_REG) ? '1 : '0;
                end
            end
            state      <= RF_IDLE;
            sweep_warp <= '0;
            sweep_idx  <= '0;
        end else begin
            // wr_accept already excludes the swept warp, so the two writes never collide.
            if (wr_accept) regs[wr_warp][wr_addr] <= wr_data;
            case (state)
                RF_IDLE: begin
                    if (init_valid) begin
                        state      <= RF_CLEAR;
                        sweep_warp <= init_warp;
                        sweep_idx  <= '0;
                    end
                end
                RF_CLEAR: begin
                    regs[sweep_warp][sweep_idx] <= (sweep_idx == RW'(MASK_REG)) ? '1 : '0;
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == RW'(NUM_REGS - 1)) state <= RF_IDLE;
                end
                default: state <= RF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_resp_valid <= 1'b0;
            rs1_data      <= '0;
            rs2_data      <= '0;
        end else begin
            rd_resp_valid <= rd_fire;
            if (rd_fire) begin
                rs1_data <= rs1_next;
                rs2_data <= rs2_next;
            end
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_mask
        assign exec_mask[w] = regs[w][MASK_REG];
    end

endmodule

// File: tb/tb_banked_scalar_reg_file.sv
// Randomised bench for banked_scalar_reg_file against an array-based model of
// the register banks, the read port and the clearing sweep.
module tb_banked_scalar_reg_file;
    import banked_scalar_reg_file_pkg::*;

    localparam int NW = 4;
    localparam int NR = 32;
    localparam int MR = 1;
    localparam int DW = 32;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   rd_req_valid;
    logic                   rd_req_ready;
    logic [1:0]             rd_warp;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic                   rd_resp_valid;
    logic [DW-1:0]          rs1_data;
    logic [DW-1:0]          rs2_data;
    logic                   wr_en;
    logic [1:0]             wr_warp;
    logic [4:0]             wr_addr;
    reg_input_mux_t         wr_mux;
    logic [DW-1:0]          alu_out;
    logic [DW-1:0]          lsu_out;
    logic [DW-1:0]          wr_immediate;
    logic                   init_valid;
    logic [1:0]             init_warp;
    logic                   init_busy;
    logic [NW-1:0][DW-1:0]  exec_mask;

    banked_scalar_reg_file #(
        .DATA_WIDTH(DW), .NUM_WARPS(NW), .NUM_REGS(NR), .MASK_REG(MR)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_warp(rd_warp), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_resp_valid(rd_resp_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wr_en(wr_en), .wr_warp(wr_warp), .wr_addr(wr_addr), .wr_mux(wr_mux),
        .alu_out(alu_out), .lsu_out(lsu_out), .wr_immediate(wr_immediate),
        .init_valid(init_valid), .init_warp(init_warp), .init_busy(init_busy),
        .exec_mask(exec_mask)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mdl [NW][NR];
    int            busy_left;
    int            sweep_idx_m;
    int            sweep_warp_m;
    logic [DW-1:0] exp_rs1;
    logic [DW-1:0] exp_rs2;
    logic          exp_resp_valid;

    int errors = 0;
    int checks = 0;

    function automatic logic exp_ready(input logic [1:0] w);
        return !(busy_left > 0 && int'(w) == sweep_warp_m);
    endfunction

    task automatic reset_model();
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                mdl[w][r] = (r == MR) ? '1 : '0;
        busy_left      = 0;
        sweep_idx_m    = 0;
        sweep_warp_m   = 0;
        exp_rs1        = '0;
        exp_rs2        = '0;
        exp_resp_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        rd_req_valid = 1'b0; rd_warp = '0; rs1_addr = '0; rs2_addr = '0;
        wr_en = 1'b0; wr_warp = '0; wr_addr = '0; wr_mux = ALU_OUT;
        alu_out = '0; lsu_out = '0; wr_immediate = '0;
        init_valid = 1'b0; init_warp = '0;
    endtask

    // Predicts the outcome of the coming edge from the current inputs, then advances the model.
    task automatic step();
        logic [DW-1:0] wval;
        logic          wok;
        logic          accept;
        case (wr_mux)
            ALU_OUT:   wval = alu_out;
            LSU_OUT:   wval = lsu_out;
            IMMEDIATE: wval = wr_immediate;
            default:   wval = '0;
        endcase
        wok    = wr_en && wr_addr != 0 && !(busy_left > 0 && int'(wr_warp) == sweep_warp_m);
        accept = rd_req_valid && exp_ready(rd_warp);
        exp_resp_valid = accept;
        if (accept) begin
            exp_rs1 = (rs1_addr == 0) ? '0 :
                      (wok && wr_warp == rd_warp && wr_addr == rs1_addr) ? wval : mdl[rd_warp][rs1_addr];
            exp_rs2 = (rs2_addr == 0) ? '0 :
                      (wok && wr_warp == rd_warp && wr_addr == rs2_addr) ? wval : mdl[rd_warp][rs2_addr];
        end
        @(posedge clk);
        if (wok) mdl[wr_warp][wr_addr] = wval;
        if (busy_left > 0) begin
            mdl[sweep_warp_m][sweep_idx_m] = (sweep_idx_m == MR) ? '1 : '0;
            sweep_idx_m++;
            busy_left--;
        end else if (init_valid) begin
            busy_left    = NR;
            sweep_idx_m  = 0;
            sweep_warp_m = int'(init_warp);
        end
        #1;
    endtask

    task automatic test_reset();
        checks++; if (rd_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", rd_resp_valid); end
        checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL reset_init_busy got=%b exp=0", init_busy); end
        checks++; if (rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin errors++; $display("FAIL reset_rs_data got=%h/%h exp=%h/%h", rs1_data, rs2_data, exp_rs1, exp_rs2); end
        for (int w = 0; w < NW; w++) begin
            checks++; if (exec_mask[w] !== mdl[w][MR]) begin errors++; $display("FAIL reset_exec_mask[%0d] got=%h exp=%h", w, exec_mask[w], mdl[w][MR]); end
        end
        rd_req_valid = 1'b1; rd_warp = 2'd2; rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1;
        checks++; if (rd_req_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready got=%b exp=1", rd_req_ready); end
        step();
        rd_req_valid = 1'b0;
        checks++; if (rd_resp_valid !== 1'b1) begin errors++; $display("FAIL reset_read_valid got=%b exp=1", rd_resp_valid); end
        checks++; if (rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin errors++; $display("FAIL reset_read_data got=%h/%h exp=%h/%h", rs1_data, rs2_data, exp_rs1, exp_rs2); end
        step();
        checks++; if (rd_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_read_pulse got=%b exp=0", rd_resp_valid); end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_warp = 2'd1; wr_addr = 5'd7; wr_mux = IMMEDIATE; wr_immediate = 32'hDEAD_BEEF;
        step();
        wr_en = 1'b0;
        // Back-to-back reads: w1 r7 then w0 r7
        rd_req_valid = 1'b1; rd_warp = 2'd1; rs1_addr = 5'd7; rs2_addr = 5'd0;
        step();
        checks++; if (rd_resp_valid !== 1'b1 || rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin
            errors++; $display("FAIL write_read_w1 got=%b %h/%h exp=1 %h/%h", rd_resp_valid, rs1_data, rs2_data, exp_rs1, exp_rs2);
        end
        rd_warp = 2'd0; rs2_addr = 5'd7;
        step();
        rd_req_valid = 1'b0;
        checks++; if (rd_resp_valid !== 1'b1 || rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin
            errors++; $display("FAIL write_read_w0 got=%b %h/%h exp=1 %h/%h", rd_resp_valid, rs1_data, rs2_data, exp_rs1, exp_rs2);
        end
        step();
        checks++; if (rs1_data !== exp_rs1) begin errors++; $display("FAIL write_read_hold got=%h exp=%h", rs1_data, exp_rs1); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_warp = 2'd3; wr_addr = 5'd4; wr_mux = ALU_OUT; alu_out = 32'h0000_1234;
        rd_req_valid = 1'b1; rd_warp = 2'd3; rs1_addr = 5'd4; rs2_addr = 5'd0;
        step();
        checks++; if (rd_resp_valid !== 1'b1 || rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin
            errors++; $display("FAIL bypass got=%b %h/%h exp=1 %h/%h", rd_resp_valid, rs1_data, rs2_data, exp_rs1, exp_rs2);
        end
        wr_addr = 5'd0; wr_mux = IMMEDIATE; wr_immediate = 32'hFFFF_FFFF;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        step();
        checks++; if (rs1_data !== exp_rs1) begin errors++; $display("FAIL bypass_r0 got=%h exp=%h", rs1_data, exp_rs1); end
        wr_en = 1'b0; rs2_addr = 5'd4;
        step();
        rd_req_valid = 1'b0;
        checks++; if (rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin
            errors++; $display("FAIL write_r0_dropped got=%h/%h exp=%h/%h", rs1_data, rs2_data, exp_rs1, exp_rs2);
        end
    endtask

    task automatic test_exec_mask();
        wr_en = 1'b1; wr_warp = 2'd2; wr_addr = 5'(MR); wr_mux = LSU_OUT; lsu_out = 32'h0000_000F;
        step();
        wr_en = 1'b0;
        for (int w = 0; w < NW; w++) begin
            checks++; if (exec_mask[w] !== mdl[w][MR]) begin errors++; $display("FAIL exec_mask[%0d] got=%h exp=%h", w, exec_mask[w], mdl[w][MR]); end
        end
    endtask

    task automatic test_sweep();
        wr_en = 1'b1; wr_mux = IMMEDIATE;
        for (int r = 2; r < NR; r++) begin
            for (int w = 0; w < 2; w++) begin
                wr_warp = 2'(w); wr_addr = 5'(r); wr_immediate = $urandom;
                step();
            end
        end
        wr_en = 1'b0;
        init_valid = 1'b1; init_warp = 2'd1;
        step();
        init_valid = 1'b0;
        for (int i = 0; i < NR; i++) begin
            checks++; if (init_busy !== (busy_left > 0)) begin errors++; $display("FAIL sweep_busy cyc=%0d got=%b exp=%b", i, init_busy, busy_left > 0); end
            rd_req_valid = 1'b1; rd_warp = (i % 2 == 1) ? 2'd0 : 2'd1;
            rs1_addr = 5'($urandom_range(0, NR - 1)); rs2_addr = 5'($urandom_range(0, NR - 1));
            if (i == 10) begin wr_en = 1'b1; wr_warp = 2'd1; wr_addr = 5'd5; wr_mux = IMMEDIATE; wr_immediate = 32'h5555_5555; end
            if (i == 11) begin init_valid = 1'b1; init_warp = 2'd0; end
            #1;
            checks++; if (rd_req_ready !== exp_ready(rd_warp)) begin errors++; $display("FAIL sweep_ready cyc=%0d warp=%0d got=%b exp=%b", i, rd_warp, rd_req_ready, exp_ready(rd_warp)); end
            step();
            wr_en = 1'b0; init_valid = 1'b0;
            checks++; if (rd_resp_valid !== exp_resp_valid) begin errors++; $display("FAIL sweep_resp cyc=%0d got=%b exp=%b", i, rd_resp_valid, exp_resp_valid); end
            checks++; if (rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin errors++; $display("FAIL sweep_data cyc=%0d got=%h/%h exp=%h/%h", i, rs1_data, rs2_data, exp_rs1, exp_rs2); end
            checks++; if (exec_mask[1] !== mdl[1][MR]) begin errors++; $display("FAIL sweep_mask cyc=%0d got=%h exp=%h", i, exec_mask[1], mdl[1][MR]); end
        end
        checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL sweep_end_busy got=%b exp=0", init_busy); end
        for (int w = 0; w < 2; w++) begin
            for (int r = 0; r < NR; r += 2) begin
                rd_req_valid = 1'b1; rd_warp = 2'(w); rs1_addr = 5'(r); rs2_addr = 5'(r + 1);
                #1;
                checks++; if (rd_req_ready !== 1'b1) begin errors++; $display("FAIL post_sweep_ready w=%0d got=%b exp=1", w, rd_req_ready); end
                step();
                checks++; if (rd_resp_valid !== 1'b1 || rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin
                    errors++; $display("FAIL post_sweep_read w=%0d r=%0d got=%b %h/%h exp=1 %h/%h", w, r, rd_resp_valid, rs1_data, rs2_data, exp_rs1, exp_rs2);
                end
            end
        end
        rd_req_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rd_req_valid = 1'($urandom); rd_warp = 2'($urandom);
            rs1_addr = 5'($urandom); rs2_addr = 5'($urandom);
            wr_en = 1'($urandom); wr_warp = ($urandom_range(0, 3) == 0) ? rd_warp : 2'($urandom);
            wr_addr = ($urandom_range(0, 2) == 0) ? rs1_addr : 5'($urandom_range(0, 3));
            wr_mux = reg_input_mux_t'(2'($urandom_range(0, 2)));
            alu_out = $urandom; lsu_out = $urandom; wr_immediate = $urandom;
            init_valid = ($urandom_range(0, 49) == 0); init_warp = 2'($urandom);
            #1;
            checks++; if (rd_req_ready !== exp_ready(rd_warp)) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, rd_req_ready, exp_ready(rd_warp)); end
            step();
            checks++; if (rd_resp_valid !== exp_resp_valid) begin errors++; $display("FAIL rand_resp cyc=%0d got=%b exp=%b", i, rd_resp_valid, exp_resp_valid); end
            checks++; if (rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin errors++; $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h", i, rs1_data, rs2_data, exp_rs1, exp_rs2); end
            checks++; if (init_busy !== (busy_left > 0)) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, init_busy, busy_left > 0); end
            for (int w = 0; w < NW; w++) begin
                checks++; if (exec_mask[w] !== mdl[w][MR]) begin errors++; $display("FAIL rand_mask cyc=%0d w=%0d got=%h exp=%h", i, w, exec_mask[w], mdl[w][MR]); end
            end
        end
        idle_inputs();
        for (int i = 0; i < NR + 1 && busy_left > 0; i++) step();
    endtask

    task automatic test_reset_mid_sweep();
        init_valid = 1'b1; init_warp = 2'd2;
        step();
        init_valid = 1'b0;
        wr_en = 1'b1; wr_warp = 2'd0; wr_addr = 5'(MR); wr_mux = ALU_OUT; alu_out = 32'h0000_00A5;
        rd_req_valid = 1'b1; rd_warp = 2'd0; rs1_addr = 5'd3; rs2_addr = 5'd4;
        for (int i = 0; i < 5; i++) step();
        idle_inputs();
        #2;
        reset_n = 1'b0;
        reset_model();
        #1;
        checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", init_busy); end
        checks++; if (rd_resp_valid !== 1'b0) begin errors++; $display("FAIL midreset_resp got=%b exp=0", rd_resp_valid); end
        checks++; if (rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin errors++; $display("FAIL midreset_data got=%h/%h exp=%h/%h", rs1_data, rs2_data, exp_rs1, exp_rs2); end
        for (int w = 0; w < NW; w++) begin
            checks++; if (exec_mask[w] !== mdl[w][MR]) begin errors++; $display("FAIL midreset_mask[%0d] got=%h exp=%h", w, exec_mask[w], mdl[w][MR]); end
        end
        #4;
        reset_n = 1'b1;
        rd_req_valid = 1'b1; rd_warp = 2'd2; rs1_addr = 5'd1; rs2_addr = 5'd9;
        #1;
        checks++; if (rd_req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", rd_req_ready); end
        step();
        rd_req_valid = 1'b0;
        checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_after got=%b exp=0", init_busy); end
        checks++; if (rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin errors++; $display("FAIL midreset_read got=%h/%h exp=%h/%h", rs1_data, rs2_data, exp_rs1, exp_rs2); end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        reset_model();
        #12;
        reset_n = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_exec_mask();
        test_sweep();
        test_random();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/banked_scalar_reg_file.md
# banked_scalar_reg_file

Parametrised multi-warp scalar register file: one bank of NUM_REGS registers per warp, shared by all warps of a core, replacing per-warp register-file instances. Adds a valid/ready read port with 1-cycle registered response, write-to-read bypass, per-warp execution-mask outputs, and a sequential per-warp re-initialisation sweep used when a warp is (re)launched. Sits between the decoder/scheduler and the ALU/LSU in the core datapath.

## Interface
- DATA_WIDTH, `DATA_WIDTH, register width
- NUM_WARPS, 4, number of banks (≥1)
- NUM_REGS, 32, registers per bank (power of two, ≥4)
- MASK_REG, 1, index of execution-mask register
- WW = max(1,$clog2(NUM_WARPS)), RW = $clog2(NUM_REGS) (derived localparams)

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_req_valid  in  1  read request
- rd_req_ready  out  1  read request can be accepted
- rd_warp  in  WW  warp of read
- rs1_addr, rs2_addr  in  RW each  source indices
- rd_resp_valid  out  1  one-cycle pulse: rs1_data/rs2_data valid
- rs1_data, rs2_data  out  DATA_WIDTH each  read data, held until next response
- wr_en  in  1  write request (always accepted unless dropped below)
- wr_warp  in  WW; wr_addr  in  RW  destination
- wr_mux  in  reg_input_mux_t  ALU_OUT / LSU_OUT / IMMEDIATE
- alu_out, lsu_out, wr_immediate  in  DATA_WIDTH each  write sources
- init_valid  in  1  request re-initialisation of init_warp
- init_warp  in  WW  warp to re-initialise
- init_busy  out  1  sweep in progress
- exec_mask  out  NUM_WARPS×DATA_WIDTH (packed, warp w at [w])  register MASK_REG of each bank

## Operation
- Register 0 of every bank reads zero; writes to it dropped.
- Write: wr_en → bank[wr_warp][wr_addr] ← source selected by wr_mux; unknown wr_mux value drops the write (simulation $error).
- Read accepted on rd_req_valid && rd_req_ready; data of both sources captured into rs1_data/rs2_data.
- Bypass: write accepted same cycle to same warp/register as an accepted read → response carries the new value (except register 0 → 0).
- rd_req_ready = !(init_busy && rd_warp == sweep warp).
- Writes to the warp under sweep are dropped; other warps unaffected.
- Init FSM states IDLE, CLEAR. IDLE + init_valid → CLEAR, latch warp, index←0. CLEAR: each cycle write index (MASK_REG ← all ones, others ← 0), index++; after index NUM_REGS-1 → IDLE. init_valid in CLEAR ignored.
- exec_mask[w] is the stored register value (no bypass).

## Timing
- Reset (async assert): all registers 0, every MASK_REG all ones, rs1_data/rs2_data 0, rd_resp_valid 0, init_busy 0, FSM IDLE; deassertion synchronous to clk.
- Read latency 1: accepted at edge N → rd_resp_valid high and data valid after edge N, for one cycle. Back-to-back reads give back-to-back responses.
- Write visible to ordinary reads accepted at edge N+1 and exec_mask after edge N; bypass covers edge N.
- init_busy rises the edge after init_valid, stays high exactly NUM_REGS cycles; warp readable the cycle init_busy falls.
- Reset mid-sweep: FSM to IDLE, all banks reset values.

## Structure
- Shared package common.sv: data_t, reg_input_mux_t (existing), new regfile_init_state_t {RF_IDLE, RF_CLEAR}.
- Storage as array [NUM_WARPS][NUM_REGS] of data_t; write-source mux and bypass in one always_comb.
- Single module; sweep FSM stays inline (≈20 lines), no sub-module.

## Test plan
- Reset → exec_mask all banks 0xFFFFFFFF, read w2 r5/r0 → 0/0, rd_resp_valid one cycle after request.
- Write w1 r7 IMMEDIATE 0xDEADBEEF; read w1 r7 next cycle → 0xDEADBEEF; read w0 r7 → 0.
- Same-cycle write w3 r4 ALU_OUT 0x1234 and read w3 r4/r0 → response 0x1234/0; write to r0 → later read 0.
- Write w2 MASK_REG LSU_OUT 0x0000000F → exec_mask[2]=0xF next cycle, others unchanged.
- Fill w1 r2..r31, init_valid w1 → init_busy high 32 cycles, rd_req_ready low for w1 only, w1 write mid-sweep dropped; after → r2..r31=0, MASK_REG all ones, w0 contents intact.
- Assert reset_n low mid-sweep and between clock edges → outputs reset immediately, init_busy 0.
